ctrl_fsm_param: RTL and testbench

Parametrised multi-cycle control unit for the simple processor datapath. It sequences fetch, decode and execute of eight opcodes. Its outputs are one-hot register-file out/in enables plus bus, ALU, PC, address and memory strobes. It adds a variable-latency memory handshake (MEM_RDY) with a watchdog timeout, conditional move, HALT, and a register count set by a parameter; the highest register is the PC.

---
 rtl/ctrl_fsm_param.sv | 257 +++++++++++++++++++++++++
 tb/tb_ctrl_fsm_param.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_fsm_param.sv
// ctrl_fsm_param
// Multi-cycle control unit for the simple processor datapath. It fetches an
// instruction through a variable-latency memory handshake, decodes it and
// sequences execution of eight opcodes:
//   mv, mvi, add, sub, ld, st, mvnz, halt
// A watchdog aborts any memory wait that lasts too long and sets a sticky
// error flag.
//
// Ports
//   i_clk        clock, all state on the rising edge
//   i_rst        synchronous active-high reset
//   i_run        start / continue execution
//   i_ir         instruction register {opcode[2:0], X, Y}
//   i_zero       zero flag, qualifies the mvnz register write
//   i_mem_rdy    memory read data valid / write accepted
//   o_rout       one-hot register bus-drive enables (MSB is the PC)
//   o_rin        one-hot register load enables (MSB is the PC)
//   o_gout, o_dinout, o_ain, o_gin, o_addsub, o_irin, o_incr, o_pcin,
//   o_addrin, o_doutin, o_w   datapath strobes (o_addsub=1 subtracts)
//   o_done       pulse on the last cycle of each instruction
//   o_halted     high while halted
//   o_err        sticky memory-timeout flag
//   o_state      current state encoding, debug
//
// state  | meaning
// IDLE   | waiting for i_run
// F_ADDR | PC -> address register
// F_WAIT | wait for instruction word, load IR, increment PC
// DECODE | dispatch on opcode (halt finishes here)
// MV     | mv / mvnz register copy
// MVI_A  | PC -> address register for the immediate word
// MVI_W  | wait for immediate, load Rx, increment PC
// ALU_A  | Rx -> A
// ALU_G  | Ry through ALU -> G
// ALU_W  | G -> Rx
// LD_A   | Ry -> address register
// LD_W   | wait for read data, load Rx
// ST_A   | Ry -> address register
// ST_D   | Rx -> data-out register
// ST_W   | hold write strobe until accepted
// HALT   | halted until i_run drops

module ctrl_fsm_param #(
    parameter int REG_BITS = 3,
    parameter int TIMEOUT  = 15
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_run,
    input  logic [3+2*REG_BITS-1:0]     i_ir,
    input  logic                        i_zero,
    input  logic                        i_mem_rdy,
    output logic [(2**REG_BITS)-1:0]    o_rout,
    output logic [(2**REG_BITS)-1:0]    o_rin,
    output logic                        o_gout,
    output logic                        o_dinout,
    output logic                        o_ain,
    output logic                        o_gin,
    output logic                        o_addsub,
    output logic                        o_irin,
    output logic                        o_incr,
    output logic                        o_pcin,
    output logic                        o_addrin,
    output logic                        o_doutin,
    output logic                        o_w,
    output logic                        o_done,
    output logic                        o_halted,
    output logic                        o_err,
    output logic [4:0]                  o_state
);

    localparam int NR    = 2**REG_BITS;
    localparam int IR_W  = 3 + 2*REG_BITS;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [4:0] {
        S_IDLE   = 5'd0,
        S_F_ADDR = 5'd1,
        S_F_WAIT = 5'd2,
        S_DECODE = 5'd3,
        S_MV     = 5'd4,
        S_MVI_A  = 5'd5,
        S_MVI_W  = 5'd6,
        S_ALU_A  = 5'd7,
        S_ALU_G  = 5'd8,
        S_ALU_W  = 5'd9,
        S_LD_A   = 5'd10,
        S_LD_W   = 5'd11,
        S_ST_A   = 5'd12,
        S_ST_D   = 5'd13,
        S_ST_W   = 5'd14,
        S_HALT   = 5'd15
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;

    logic [2:0]          w_op;
    logic [REG_BITS-1:0] w_x;
    logic [REG_BITS-1:0] w_y;
    logic                w_in_wait;
    logic                w_timeout;
    state_t              w_after_done;

    assign w_op = i_ir[IR_W-1 -: 3];
    assign w_x  = i_ir[2*REG_BITS-1 -: REG_BITS];
    assign w_y  = i_ir[REG_BITS-1:0];

    assign w_in_wait = (r_state == S_F_WAIT) || (r_state == S_MVI_W) ||
                       (r_state == S_LD_W)   || (r_state == S_ST_W);

    // Abort on the TIMEOUT-th consecutive wait cycle that is still not ready;
    // ready on that same cycle wins.
    assign w_timeout = (TIMEOUT != 0) && w_in_wait && !i_mem_rdy &&
                       ((r_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT));

    assign w_after_done = i_run ? S_F_ADDR : S_IDLE;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            // Wait states are never adjacent, so clearing outside them is
            // equivalent to clearing on entry.
            if (w_in_wait && !i_mem_rdy) r_cnt <= r_cnt + CNT_W'(1);
            else                         r_cnt <= '0;

            if (w_timeout) begin
                r_err   <= 1'b1;
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: if (i_run) begin
                        r_err   <= 1'b0;
                        r_state <= S_F_ADDR;
                    end
                    S_F_ADDR: r_state <= S_F_WAIT;
                    S_F_WAIT: if (i_mem_rdy) r_state <= S_DECODE;
                    S_DECODE: begin
                        case (w_op)
                            3'b000, 3'b110: r_state <= S_MV;
                            3'b001:         r_state <= S_MVI_A;
                            3'b010, 3'b011: r_state <= S_ALU_A;
                            3'b100:         r_state <= S_LD_A;
                            3'b101:         r_state <= S_ST_A;
                            default:        r_state <= S_HALT;
                        endcase
                    end
                    S_MV:    r_state <= w_after_done;
                    S_MVI_A: r_state <= S_MVI_W;
                    S_MVI_W: if (i_mem_rdy) r_state <= w_after_done;
                    S_ALU_A: r_state <= S_ALU_G;
                    S_ALU_G: r_state <= S_ALU_W;
                    S_ALU_W: r_state <= w_after_done;
                    S_LD_A:  r_state <= S_LD_W;
                    S_LD_W:  if (i_mem_rdy) r_state <= w_after_done;
                    S_ST_A:  r_state <= S_ST_D;
                    S_ST_D:  r_state <= S_ST_W;
                    S_ST_W:  if (i_mem_rdy) r_state <= w_after_done;
                    S_HALT:  if (!i_run) r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Strobes are decoded from the state register plus the handshake inputs:
    // the load that completes a memory wait must land in the same cycle
    // MEM_RDY is seen, and reset has to kill W/Rin in the cycle it arrives.
    always_comb begin
        o_rout   = '0;
        o_rin    = '0;
        o_gout   = 1'b0;
        o_dinout = 1'b0;
        o_ain    = 1'b0;
        o_gin    = 1'b0;
        o_addsub = 1'b0;
        o_irin   = 1'b0;
        o_incr   = 1'b0;
        o_addrin = 1'b0;
        o_doutin = 1'b0;
        o_w      = 1'b0;
        o_done   = 1'b0;
        o_halted = 1'b0;
        if (!i_rst) begin
            case (r_state)
                S_F_ADDR: begin
                    o_rout[NR-1] = 1'b1;
                    o_addrin     = 1'b1;
                end
                S_F_WAIT: if (i_mem_rdy) begin
                    o_irin = 1'b1;
                    o_incr = 1'b1;
                end
                S_DECODE: o_done = (w_op == 3'b111);
                S_MV: begin
                    o_rout = NR'(1) << w_y;
                    if (!((w_op == 3'b110) && i_zero)) o_rin = NR'(1) << w_x;
                    o_done = 1'b1;
                end
                S_MVI_A: begin
                    o_rout[NR-1] = 1'b1;
                    o_addrin     = 1'b1;
                end
                S_MVI_W: if (i_mem_rdy) begin
                    o_dinout = 1'b1;
                    o_rin    = NR'(1) << w_x;
                    // mvi into the PC is a jump: the load replaces the
                    // increment so the two never hit the PC together.
                    o_incr   = !(&w_x);
                    o_done   = 1'b1;
                end
                S_ALU_A: begin
                    o_rout = NR'(1) << w_x;
                    o_ain  = 1'b1;
                end
                S_ALU_G: begin
                    o_rout   = NR'(1) << w_y;
                    o_gin    = 1'b1;
                    o_addsub = w_op[0];
                end
                S_ALU_W: begin
                    o_gout = 1'b1;
                    o_rin  = NR'(1) << w_x;
                    o_done = 1'b1;
                end
                S_LD_A, S_ST_A: begin
                    o_rout   = NR'(1) << w_y;
                    o_addrin = 1'b1;
                end
                S_LD_W: if (i_mem_rdy) begin
                    o_dinout = 1'b1;
                    o_rin    = NR'(1) << w_x;
                    o_done   = 1'b1;
                end
                S_ST_D: begin
                    o_rout   = NR'(1) << w_x;
                    o_doutin = 1'b1;
                end
                S_ST_W: begin
                    o_w    = 1'b1;
                    o_done = i_mem_rdy;
                end
                S_HALT:  o_halted = 1'b1;
                default: ;
            endcase
        end
        o_pcin = o_incr | o_rin[NR-1];
    end

    assign o_err   = r_err;
    assign o_state = r_state;

endmodule

// File: tb/tb_ctrl_fsm_param.sv
module tb_ctrl_fsm_param;

    localparam logic [4:0] IDLE = 5'd0,  F_ADDR = 5'd1, F_WAIT = 5'd2,
                           DECODE = 5'd3, MV = 5'd4,   MVI_A = 5'd5,
                           MVI_W = 5'd6, ALU_A = 5'd7, ALU_G = 5'd8,
                           ALU_W = 5'd9, LD_A = 5'd10, LD_W = 5'd11,
                           ST_A = 5'd12, ST_D = 5'd13, ST_W = 5'd14,
                           HALT = 5'd15;

    localparam logic [13:0] GOUT = 14'h2000, DINOUT = 14'h1000, AIN = 14'h0800,
                            GIN = 14'h0400, ADDSUB = 14'h0200, IRIN = 14'h0100,
                            INCR = 14'h0080, PCIN = 14'h0040, ADDRIN = 14'h0020,
                            DOUTIN = 14'h0010, WR = 14'h0008, DONE = 14'h0004,
                            HALTED = 14'h0002, ERR = 14'h0001, NONE = 14'h0000;

    localparam logic [8:0] I_MV   = 9'b000_001_010;
    localparam logic [8:0] I_MVI  = 9'b001_011_000;
    localparam logic [8:0] I_ADD  = 9'b010_000_011;
    localparam logic [8:0] I_SUB  = 9'b011_000_011;
    localparam logic [8:0] I_LD   = 9'b100_010_100;
    localparam logic [8:0] I_ST   = 9'b101_101_110;
    localparam logic [8:0] I_MVNZ = 9'b110_001_010;
    localparam logic [8:0] I_HALT = 9'b111_000_000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, run, zero, rdy;
    logic [8:0] ir;
    logic [7:0] rout, rin;
    logic gout, dinout, ain, gin, addsub, irin, incr, pcin, addrin, doutin;
    logic w, done, halted, err;
    logic [4:0] state;

    ctrl_fsm_param #(.REG_BITS(3), .TIMEOUT(15)) dut (
        .i_clk(clk), .i_rst(rst), .i_run(run), .i_ir(ir), .i_zero(zero),
        .i_mem_rdy(rdy), .o_rout(rout), .o_rin(rin), .o_gout(gout),
        .o_dinout(dinout), .o_ain(ain), .o_gin(gin), .o_addsub(addsub),
        .o_irin(irin), .o_incr(incr), .o_pcin(pcin), .o_addrin(addrin),
        .o_doutin(doutin), .o_w(w), .o_done(done), .o_halted(halted),
        .o_err(err), .o_state(state)
    );

    typedef struct packed {
        logic       rst;
        logic       run;
        logic       rdy;
        logic       zero;
        logic [8:0] ir;
    } stim_t;

    typedef struct packed {
        logic [34:0] v;
        logic [34:0] m;
    } exp_t;

    stim_t sq[$];
    exp_t  eq[$];
    int    n_vec  = 0;
    int    n_miss = 0;

    function automatic logic [34:0] act_v();
        return {state, rout, rin, gout, dinout, ain, gin, addsub, irin, incr,
                pcin, addrin, doutin, w, done, halted, err};
    endfunction

    // Queue one cycle of stimulus and the outputs expected in that cycle.
    task automatic push(input logic p_rst, p_run, p_rdy, p_zero,
                        input logic [8:0] p_ir, input logic [4:0] st,
                        input logic [7:0] ro, ri, input logic [13:0] s,
                        input logic chk_st);
        stim_t       sv;
        exp_t        ev;
        logic [34:0] m;
        sv.rst = p_rst; sv.run = p_run; sv.rdy = p_rdy; sv.zero = p_zero;
        sv.ir = p_ir;
        m = '1;
        if (!chk_st) m[34:30] = 5'b0;
        ev.v = {st, ro, ri, s};
        ev.m = m;
        sq.push_back(sv);
        eq.push_back(ev);
    endtask

    // Fetch and decode of a non-halt instruction with memory ready at once.
    task automatic push_fetch(input logic [8:0] p_ir, input logic p_run);
        push(0, p_run, 1, 0, p_ir, F_ADDR, 8'h80, 8'h00, ADDRIN, 1);
        push(0, p_run, 1, 0, p_ir, F_WAIT, 8'h00, 8'h00, IRIN | INCR | PCIN, 1);
        push(0, p_run, 1, 0, p_ir, DECODE, 8'h00, 8'h00, NONE, 1);
    endtask

    task automatic drive_next();
        stim_t s;
        s = sq.pop_front();
        rst = s.rst; run = s.run; rdy = s.rdy; zero = s.zero; ir = s.ir;
    endtask

    task automatic test_reset();
        exp_t e; logic [34:0] a; int k = 0;
        push(1, 1, 1, 0, I_MV, IDLE, 8'h00, 8'h00, NONE, 1);
        push(1, 1, 1, 1, I_LD, IDLE, 8'h00, 8'h00, NONE, 1);
        push(0, 0, 1, 0, I_MV, IDLE, 8'h00, 8'h00, NONE, 1);
        while (eq.size() > 0) begin
            drive_next(); #4;
            e = eq.pop_front(); a = act_v(); n_vec++;
            if ((a & e.m) !== (e.v & e.m)) begin
                n_miss++;
                $display("FAIL reset step %0d: got %h expected %h", k, a, e.v);
            end
            k++; @(posedge clk); #1;
        end
    endtask

    task automatic test_mv_back_to_back();
        exp_t e; logic [34:0] a; int k = 0;
        push(0, 1, 1, 0, I_MV, IDLE, 8'h00, 8'h00, NONE, 1);
        push_fetch(I_MV, 1);
        push(0, 1, 1, 0, I_MV, MV, 8'h04, 8'h02, DONE, 1);
        push_fetch(I_MV, 0);
        push(0, 0, 1, 0, I_MV, MV, 8'h04, 8'h02, DONE, 1);
        push(0, 0, 1, 0, I_MV, IDLE, 8'h00, 8'h00, NONE, 1);
        while (eq.size() > 0) begin
            drive_next(); #4;
            e = eq.pop_front(); a = act_v(); n_vec++;
            if ((a & e.m) !== (e.v & e.m)) begin
                n_miss++;
                $display("FAIL mv_back_to_back step %0d: got %h expected %h", k, a, e.v);
            end
            k++; @(posedge clk); #1;
        end
    endtask

    task automatic test_alu();
        exp_t e; logic [34:0] a; int k = 0;
        push(0, 1, 1, 0, I_ADD, IDLE, 8'h00, 8'h00, NONE, 1);
        push_fetch(I_ADD, 1);
        push(0, 1, 1, 0, I_ADD, ALU_A, 8'h01, 8'h00, AIN, 1);
        push(0, 1, 1, 0, I_ADD, ALU_G, 8'h08, 8'h00, GIN, 1);
        push(0, 1, 1, 0, I_ADD, ALU_W, 8'h00, 8'h01, GOUT | DONE, 1);
        push_fetch(I_SUB, 0);
        push(0, 0, 1, 0, I_SUB, ALU_A, 8'h01, 8'h00, AIN, 1);
        push(0, 0, 1, 0, I_SUB, ALU_G, 8'h08, 8'h00, GIN | ADDSUB, 1);
        push(0, 0, 1, 0, I_SUB, ALU_W, 8'h00, 8'h01, GOUT | DONE, 1);
        push(0, 0, 1, 0, I_SUB, IDLE, 8'h00, 8'h00, NONE, 1);
        while (eq.size() > 0) begin
            drive_next(); #4;
            e = eq.pop_front(); a = act_v(); n_vec++;
            if ((a & e.m) !== (e.v & e.m)) begin
                n_miss++;
                $display("FAIL alu step %0d: got %h expected %h", k, a, e.v);
            end
            k++; @(posedge clk); #1;
        end
    endtask

    task automatic test_st_wait();
        exp_t e; logic [34:0] a; int k = 0;
        push(0, 1, 1, 0, I_ST, IDLE, 8'h00, 8'h00, NONE, 1);
        push_fetch(I_ST, 0);
        push(0, 0, 1, 0, I_ST, ST_A, 8'h40, 8'h00, ADDRIN, 1);
        push(0, 0, 1, 0, I_ST, ST_D, 8'h20, 8'h00, DOUTIN, 1);
        for (int i = 0; i < 3; i++)
            push(0, 0, 0, 0, I_ST, ST_W, 8'h00, 8'h00, WR, 1);
        push(0, 0, 1, 0, I_ST, ST_W, 8'h00, 8'h00, WR | DONE, 1);
        push(0, 0, 1, 0, I_ST, IDLE, 8'h00, 8'h00, NONE, 1);
        while (eq.size() > 0) begin
            drive_next(); #4;
            e = eq.pop_front(); a = act_v(); n_vec++;
            if ((a & e.m) !== (e.v & e.m)) begin
                n_miss++;
                $display("FAIL st_wait step %0d: got %h expected %h", k, a, e.v);
            end
            k++; @(posedge clk); #1;
        end
    endtask

    task automatic test_mvnz();
        exp_t e; logic [34:0] a; int k = 0;
        push(0, 1, 1, 1, I_MVNZ, IDLE, 8'h00, 8'h00, NONE, 1);
        push_fetch(I_MVNZ, 1);
        push(0, 1, 1, 1, I_MVNZ, MV, 8'h04, 8'h00, DONE, 1);
        push_fetch(I_MVNZ, 0);
        push(0, 0, 1, 0, I_MVNZ, MV, 8'h04, 8'h02, DONE, 1);
        push(0, 0, 1, 0, I_MVNZ, IDLE, 8'h00, 8'h00, NONE, 1);
        while (eq.size() > 0) begin
            drive_next(); #4;
            e = eq.pop_front(); a = act_v(); n_vec++;
            if ((a & e.m) !== (e.v & e.m)) begin
                n_miss++;
                $display("FAIL mvnz step %0d: got %h expected %h", k, a, e.v);
            end
            k++; @(posedge clk); #1;
        end
    endtask

    task automatic test_mvi();
        exp_t e; logic [34:0] a; int k = 0;
        push(0, 1, 1, 0, I_MVI, IDLE, 8'h00, 8'h00, NONE, 1);
        push_fetch(I_MVI, 0);
        push(0, 0, 1, 0, I_MVI, MVI_A, 8'h80, 8'h00, ADDRIN, 1);
        push(0, 0, 0, 0, I_MVI, MVI_W, 8'h00, 8'h00, NONE, 1);
        push(0, 0, 1, 0, I_MVI, MVI_W, 8'h00, 8'h08, DINOUT | INCR | PCIN | DONE, 1);
        push(0, 0, 1, 0, I_MVI, IDLE, 8'h00, 8'h00, NONE, 1);
        while (eq.size() > 0) begin
            drive_next(); #4;
            e = eq.pop_front(); a = act_v(); n_vec++;
            if ((a & e.m) !== (e.v & e.m)) begin
                n_miss++;
                $display("FAIL mvi step %0d: got %h expected %h", k, a, e.v);
            end
            k++; @(posedge clk); #1;
        end
    endtask

    task automatic test_ld_timeout();
        exp_t e; logic [34:0] a; int k = 0;
        push(0, 1, 1, 0, I_LD, IDLE, 8'h00, 8'h00, NONE, 1);
        push_fetch(I_LD, 0);
        push(0, 0, 1, 0, I_LD, LD_A, 8'h10, 8'h00, ADDRIN, 1);
        for (int i = 0; i < 15; i++)
            push(0, 0, 0, 0, I_LD, LD_W, 8'h00, 8'h00, NONE, 1);
        push(0, 0, 0, 0, I_LD, IDLE, 8'h00, 8'h00, ERR, 1);
        push(0, 0, 1, 0, I_LD, IDLE, 8'h00, 8'h00, ERR, 1);
        push(0, 1, 1, 0, I_LD, IDLE, 8'h00, 8'h00, ERR, 1);
        push_fetch(I_LD, 0);
        push(0, 0, 1, 0, I_LD, LD_A, 8'h10, 8'h00, ADDRIN, 1);
        push(0, 0, 1, 0, I_LD, LD_W, 8'h00, 8'h04, DINOUT | DONE, 1);
        push(0, 0, 1, 0, I_LD, IDLE, 8'h00, 8'h00, NONE, 1);
        while (eq.size() > 0) begin
            drive_next(); #4;
            e = eq.pop_front(); a = act_v(); n_vec++;
            if ((a & e.m) !== (e.v & e.m)) begin
                n_miss++;
                $display("FAIL ld_timeout step %0d: got %h expected %h", k, a, e.v);
            end
            k++; @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout_edge();
        exp_t e; logic [34:0] a; int k = 0;
        push(0, 1, 1, 0, I_MV, IDLE, 8'h00, 8'h00, NONE, 1);
        push(0, 0, 1, 0, I_MV, F_ADDR, 8'h80, 8'h00, ADDRIN, 1);
        for (int i = 0; i < 14; i++)
            push(0, 0, 0, 0, I_MV, F_WAIT, 8'h00, 8'h00, NONE, 1);
        push(0, 0, 1, 0, I_MV, F_WAIT, 8'h00, 8'h00, IRIN | INCR | PCIN, 1);
        push(0, 0, 1, 0, I_MV, DECODE, 8'h00, 8'h00, NONE, 1);
        push(0, 0, 1, 0, I_MV, MV, 8'h04, 8'h02, DONE, 1);
        push(0, 0, 1, 0, I_MV, IDLE, 8'h00, 8'h00, NONE, 1);
        while (eq.size() > 0) begin
            drive_next(); #4;
            e = eq.pop_front(); a = act_v(); n_vec++;
            if ((a & e.m) !== (e.v & e.m)) begin
                n_miss++;
                $display("FAIL timeout_edge step %0d: got %h expected %h", k, a, e.v);
            end
            k++; @(posedge clk); #1;
        end
    endtask

    task automatic test_halt();
        exp_t e; logic [34:0] a; int k = 0;
        push(0, 1, 1, 0, I_HALT, IDLE, 8'h00, 8'h00, NONE, 1);
        push(0, 1, 1, 0, I_HALT, F_ADDR, 8'h80, 8'h00, ADDRIN, 1);
        push(0, 1, 1, 0, I_HALT, F_WAIT, 8'h00, 8'h00, IRIN | INCR | PCIN, 1);
        push(0, 1, 1, 0, I_HALT, DECODE, 8'h00, 8'h00, DONE, 1);
        push(0, 1, 1, 0, I_HALT, HALT, 8'h00, 8'h00, HALTED, 1);
        push(0, 1, 1, 0, I_HALT, HALT, 8'h00, 8'h00, HALTED, 1);
        push(0, 0, 1, 0, I_HALT, HALT, 8'h00, 8'h00, HALTED, 1);
        push(0, 0, 1, 0, I_HALT, IDLE, 8'h00, 8'h00, NONE, 1);
        while (eq.size() > 0) begin
            drive_next(); #4;
            e = eq.pop_front(); a = act_v(); n_vec++;
            if ((a & e.m) !== (e.v & e.m)) begin
                n_miss++;
                $display("FAIL halt step %0d: got %h expected %h", k, a, e.v);
            end
            k++; @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e; logic [34:0] a; int k = 0;
        push(0, 1, 1, 0, I_LD, IDLE, 8'h00, 8'h00, NONE, 1);
        push_fetch(I_LD, 1);
        push(0, 1, 1, 0, I_LD, LD_A, 8'h10, 8'h00, ADDRIN, 1);
        push(0, 1, 0, 0, I_LD, LD_W, 8'h00, 8'h00, NONE, 1);
        push(1, 1, 1, 0, I_LD, LD_W, 8'h00, 8'h00, NONE, 0);
        push(0, 0, 1, 0, I_LD, IDLE, 8'h00, 8'h00, NONE, 1);
        push(0, 1, 1, 0, I_ST, IDLE, 8'h00, 8'h00, NONE, 1);
        push_fetch(I_ST, 1);
        push(0, 1, 1, 0, I_ST, ST_A, 8'h40, 8'h00, ADDRIN, 1);
        push(0, 1, 1, 0, I_ST, ST_D, 8'h20, 8'h00, DOUTIN, 1);
        push(0, 1, 0, 0, I_ST, ST_W, 8'h00, 8'h00, WR, 1);
        push(1, 1, 0, 0, I_ST, ST_W, 8'h00, 8'h00, NONE, 0);
        push(0, 0, 0, 0, I_ST, IDLE, 8'h00, 8'h00, NONE, 1);
        while (eq.size() > 0) begin
            drive_next(); #4;
            e = eq.pop_front(); a = act_v(); n_vec++;
            if ((a & e.m) !== (e.v & e.m)) begin
                n_miss++;
                $display("FAIL reset_mid step %0d: got %h expected %h", k, a, e.v);
            end
            k++; @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; rdy = 1'b0; zero = 1'b0; ir = '0;
        @(posedge clk); #1;
        test_reset();
        test_mv_back_to_back();
        test_alu();
        test_st_wait();
        test_mvnz();
        test_mvi();
        test_ld_timeout();
        test_timeout_edge();
        test_halt();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
